// File: rtl/pool_stream_pkg.sv
// cnn_pkg: shared types and sizing helpers for the CNN pooling datapath.
//   pool_mode_e  - pooling operator selected per frame (max or average).
//   acc_width()  - accumulator width able to hold a full window sum.
//   avg_shift()  - right shift that divides a window sum by K*K.
package cnn_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // A KxK window sum of DATA_WIDTH-bit pixels needs 2*log2(K) extra bits.
  function automatic int acc_width(input int data_width, input int kernel_size);
    return data_width + 2 * $clog2(kernel_size);
  endfunction

  // K is a power of two, so the average is a plain right shift.
  function automatic int avg_shift(input int kernel_size);
    return 2 * $clog2(kernel_size);
  endfunction

endpackage

// File: rtl/pool_acc_lane.sv
// pool_acc_lane: per-channel pooling datapath, purely combinational.
//   i_first  - pixel opens a new window; accumulator is overwritten.
//   i_mode   - POOL_MAX keeps the running maximum, POOL_AVG the running sum.
//   i_acc    - current accumulator value for this window column.
//   i_pixel  - incoming channel pixel.
//   o_acc    - next accumulator value.
//   o_result - pooled value if this pixel completes the window.
module pool_acc_lane
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 2,
  localparam int ACC_W      = acc_width(DATA_WIDTH, KERNEL_SIZE)
) (
  input  logic                  i_first,
  input  pool_mode_e            i_mode,
  input  logic [ACC_W-1:0]      i_acc,
  input  logic [DATA_WIDTH-1:0] i_pixel,
  output logic [ACC_W-1:0]      o_acc,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int SHIFT = avg_shift(KERNEL_SIZE);

  logic [ACC_W-1:0] w_pix_ext;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_max;

  assign w_pix_ext = ACC_W'(i_pixel);
  assign w_sum     = i_acc + w_pix_ext;
  assign w_max     = (i_acc > w_pix_ext) ? i_acc : w_pix_ext;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    o_acc = w_pix_ext;
    if (!i_first) begin
      o_acc = (i_mode == POOL_AVG) ? w_sum : w_max;
    end
  end

  // In MAX mode the accumulator never exceeds the pixel range; in AVG mode the
  // shifted window sum is at most the largest pixel value, so truncation is exact.
  assign o_result = (i_mode == POOL_AVG) ? DATA_WIDTH'(o_acc >> SHIFT)
                                         : o_acc[DATA_WIDTH-1:0];

endmodule

// File: rtl/pool_stream.sv
// pool_stream: streaming KxK non-overlapping max/avg pooling over a raster
// pixel stream, all channels packed per beat.
//   clk, rst_n          - clock and asynchronous active-low reset.
//   clear               - synchronous frame abort; wins over an input beat.
//   mode                - 0 max / 1 average, captured on pixel (0,0).
//   in_valid/in_ready   - input handshake; in_data packs channel c at
//                         [c*DATA_WIDTH +: DATA_WIDTH].
//   out_valid/out_ready - output handshake; out_data uses the same packing,
//                         out_last flags the final pooled beat of a frame.
module pool_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int INPUT_CHANNELS = 1,
  parameter int KERNEL_SIZE    = 2,
  parameter int IMG_WIDTH      = 8,
  parameter int IMG_HEIGHT     = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 mode,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH*INPUT_CHANNELS-1:0] in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH*INPUT_CHANNELS-1:0] out_data,
  output logic                                 out_last
);

  localparam int ACC_W  = acc_width(DATA_WIDTH, KERNEL_SIZE);
  localparam int LOG2K  = $clog2(KERNEL_SIZE);
  localparam int NWIN   = IMG_WIDTH / KERNEL_SIZE;
  localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int WIN_W  = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int BEAT_W = DATA_WIDTH * INPUT_CHANNELS;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

  if (KERNEL_SIZE < 2 || (KERNEL_SIZE & (KERNEL_SIZE - 1)) != 0) begin : g_bad_kernel
    $fatal(1, "pool_stream: KERNEL_SIZE must be a power of 2 and at least 2");
  end
  if ((IMG_WIDTH % KERNEL_SIZE) != 0 || (IMG_HEIGHT % KERNEL_SIZE) != 0) begin : g_bad_dims
    $fatal(1, "pool_stream: image dimensions must be multiples of KERNEL_SIZE");
  end

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  pool_mode_e        r_mode;
  logic [ACC_W-1:0]  r_acc [NWIN][INPUT_CHANNELS];
  logic              r_out_valid;
  logic [BEAT_W-1:0] r_out_data;
  logic              r_out_last;

  logic              w_accept;
  logic              w_first;
  logic              w_complete;
  logic              w_frame_start;
  logic              w_frame_end;
  logic [WIN_W-1:0]  w_win;
  pool_mode_e        w_mode_eff;
  logic [ACC_W-1:0]  w_acc_next [INPUT_CHANNELS];
  logic [BEAT_W-1:0] w_result;

  // The output register is only reloaded when it is empty or draining, so a
  // stalled output blocks every input beat, completing or not.
  assign in_ready      = !r_out_valid || out_ready;
  assign w_accept      = in_valid && in_ready && !clear;
  assign w_first       = (r_row[LOG2K-1:0] == '0) && (r_col[LOG2K-1:0] == '0);
  assign w_complete    = (&r_row[LOG2K-1:0]) && (&r_col[LOG2K-1:0]);
  assign w_frame_start = (r_row == '0) && (r_col == '0);
  assign w_frame_end   = (r_row == ROW_MAX) && (r_col == COL_MAX);
  assign w_win         = WIN_W'(r_col >> LOG2K);
  // Pixel (0,0) overwrites its accumulator, so using the live mode there only
  // keeps the lane select consistent with the value being latched.
  assign w_mode_eff    = w_frame_start ? pool_mode_e'(mode) : r_mode;

  for (genvar c = 0; c < INPUT_CHANNELS; c++) begin : g_lane
    pool_acc_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .KERNEL_SIZE(KERNEL_SIZE)
    ) u_lane (
      .i_first (w_first),
      .i_mode  (w_mode_eff),
      .i_acc   (r_acc[w_win][c]),
      .i_pixel (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .o_acc   (w_acc_next[c]),
      .o_result(w_result[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_mode <= POOL_MAX;
    end else if (clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_frame_start) begin
        r_mode <= pool_mode_e'(mode);
      end
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // NOTE: the line buffer has no reset; the first pixel of every window
  // overwrites its entry, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int c = 0; c < INPUT_CHANNELS; c++) begin
        r_acc[w_win][c] <= w_acc_next[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_accept && w_complete) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_last  <= w_frame_end;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_pool_stream.sv
module tb_pool_stream;

  localparam int DW = 8;
  localparam int C  = 2;
  localparam int K  = 2;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int BW = DW * C;

  typedef struct {
    logic [BW-1:0] data;
    logic          mode;
    logic          completes;
  } beat_t;

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_data;
  logic          out_last;

  int cmp_cnt = 0;
  int err_cnt = 0;

  beat_t         tx_q[$];
  exp_t          exp_q[$];
  logic [BW-1:0] frame_pix [N];
  logic          frame_mode [N];

  pool_stream #(
    .DATA_WIDTH    (DW),
    .INPUT_CHANNELS(C),
    .KERNEL_SIZE   (K),
    .IMG_WIDTH     (W),
    .IMG_HEIGHT    (H)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic completes_at(input int idx);
    return ((idx / W) % K == K - 1) && ((idx % W) % K == K - 1);
  endfunction

  // Ramp frame: ch0 = p, ch1 = 15 - p.
  task automatic fill_ramp(input logic m);
    for (int i = 0; i < N; i++) begin
      frame_pix[i]  = {8'(15 - i), 8'(i)};
      frame_mode[i] = m;
    end
  endtask

  // Queue the frame's beats and compute its pooled outputs window by window.
  task automatic push_frame();
    logic m;
    exp_t e;
    m = frame_mode[0];
    for (int i = 0; i < N; i++) begin
      tx_q.push_back('{data: frame_pix[i], mode: frame_mode[i], completes: completes_at(i)});
    end
    for (int wr = 0; wr < H / K; wr++) begin
      for (int wc = 0; wc < W / K; wc++) begin
        e.data = '0;
        for (int c = 0; c < C; c++) begin
          int mx;
          int sum;
          mx  = 0;
          sum = 0;
          for (int dy = 0; dy < K; dy++) begin
            for (int dx = 0; dx < K; dx++) begin
              int v;
              v = int'((frame_pix[(wr * K + dy) * W + wc * K + dx] >> (c * DW)) & 16'h00FF);
              sum += v;
              if (v > mx) mx = v;
            end
          end
          e.data[c*DW +: DW] = 8'(m ? sum / (K * K) : mx);
        end
        e.last = (wr == H / K - 1) && (wc == W / K - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Drive queued beats and consume outputs until both queues drain, or until
  // max_acc beats have been accepted.
  task automatic run(input int valid_pct, input int ready_pct, input int budget,
                     input int max_acc, output int cycles);
    int  acc;
    bit  pend_chk;
    exp_t e;
    acc      = 0;
    pend_chk = 0;
    cycles   = 0;
    while ((tx_q.size() > 0 || exp_q.size() > 0) && acc < max_acc && cycles < budget) begin
      @(posedge clk);
      #1;
      in_valid = (tx_q.size() > 0) && ($urandom_range(99) < valid_pct);
      if (tx_q.size() > 0) begin
        in_data = tx_q[0].data;
        mode    = tx_q[0].mode;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      cmp_cnt++;
      if (in_ready !== (!out_valid || out_ready)) begin
        err_cnt++;
        $display("FAIL in_ready_rule: got %b want %b", in_ready, (!out_valid || out_ready));
      end
      if (pend_chk) begin
        cmp_cnt++;
        if (out_valid !== 1'b1) begin
          err_cnt++;
          $display("FAIL latency: out_valid=%b one cycle after completing accept, want 1", out_valid);
        end
        pend_chk = 0;
      end
      if (out_valid === 1'b1 && out_ready) begin
        cmp_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL spurious_output: got data=%h last=%b, none expected", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            err_cnt++;
            $display("FAIL pooled_beat: got data=%h last=%b want data=%h last=%b",
                     out_data, out_last, e.data, e.last);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        pend_chk = tx_q[0].completes;
        void'(tx_q.pop_front());
        acc++;
      end
      cycles++;
    end
    if (acc < max_acc && (tx_q.size() > 0 || exp_q.size() > 0)) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL timeout: %0d beats and %0d outputs left after %0d cycles",
               tx_q.size(), exp_q.size(), cycles);
      tx_q.delete();
      exp_q.delete();
    end
    if (acc >= max_acc) return;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cmp_cnt++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_state: valid=%b data=%h last=%b in_ready=%b want 0/0/0/1",
               out_valid, out_data, out_last, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_max_ramp();
    int cyc;
    fill_ramp(1'b0);
    push_frame();
    run(100, 100, 500, 1 << 30, cyc);
  endtask

  task automatic test_avg();
    int cyc;
    fill_ramp(1'b1);
    push_frame();
    run(100, 100, 500, 1 << 30, cyc);
    for (int i = 0; i < N; i++) begin
      frame_pix[i]  = '1;
      frame_mode[i] = 1'b1;
    end
    push_frame();
    run(100, 100, 500, 1 << 30, cyc);
  endtask

  task automatic test_backpressure();
    int cyc;
    fill_ramp(1'b0);
    push_frame();
    run(100, 100, 500, 6, cyc);
    for (int s = 0; s < 5; s++) begin
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = tx_q[0].data;
      @(negedge clk);
      cmp_cnt++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0].data || in_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL stall_hold: valid=%b data=%h in_ready=%b want 1/%h/0",
                 out_valid, out_data, in_ready, exp_q[0].data);
      end
    end
    run(100, 100, 500, 1 << 30, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    fill_ramp(1'b0);
    for (int i = 6; i < N; i++) frame_mode[i] = 1'b1;
    push_frame();
    fill_ramp(1'b1);
    push_frame();
    run(100, 100, 500, 1 << 30, cyc);
    cmp_cnt++;
    if (cyc != 2 * N + 1) begin
      err_cnt++;
      $display("FAIL back_to_back_cycles: got %0d want %0d", cyc, 2 * N + 1);
    end
  endtask

  task automatic test_abort(input bit use_reset, input int n_acc);
    int cyc;
    logic          pend;
    logic [BW-1:0] pend_data;
    fill_ramp(1'b0);
    push_frame();
    run(100, 100, 500, n_acc, cyc);
    pend      = completes_at(n_acc - 1);
    pend_data = exp_q[0].data;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = tx_q[0].data;
    @(negedge clk);
    cmp_cnt++;
    if (out_valid !== pend || (pend && out_data !== pend_data)) begin
      err_cnt++;
      $display("FAIL pre_abort: valid=%b data=%h want valid=%b data=%h",
               out_valid, out_data, pend, pend_data);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    if (use_reset) rst_n = 1'b0;
    else clear = 1'b1;
    @(negedge clk);
    if (use_reset) begin
      cmp_cnt++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
        err_cnt++;
        $display("FAIL async_reset: valid=%b data=%h last=%b want all 0",
                 out_valid, out_data, out_last);
      end
    end
    @(posedge clk);
    #1;
    clear    = 1'b0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      err_cnt++;
      $display("FAIL post_abort: valid=%b last=%b want 0/0", out_valid, out_last);
    end
    tx_q.delete();
    exp_q.delete();
    fill_ramp(1'b0);
    push_frame();
    run(100, 100, 500, 1 << 30, cyc);
  endtask

  task automatic test_random();
    int cyc;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) begin
        frame_pix[i]  = BW'($urandom);
        frame_mode[i] = 1'($urandom);
      end
      push_frame();
    end
    run(70, 60, 4000, 1 << 30, cyc);
  endtask

  initial begin
    test_reset();
    test_max_ramp();
    test_avg();
    test_backpressure();
    test_back_to_back();
    test_abort(1'b0, 10);
    test_abort(1'b0, 8);
    test_abort(1'b1, 8);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
